// File: rtl/multicycle_main_control.sv
// Main control FSM for the SOIN-RV multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects and
// strobes, and handshakes with a variable-latency memory via i_MemReady.
// Optional feature macro: CONTROL_TRAP_EN (illegal opcode traps instead of
// retiring as a NOP).
module multicycle_main_control #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [6:0]             i_Opcode,
  input  logic [2:0]             i_Funct3,
  input  logic                   i_Zero,
  input  logic                   i_Lt,
  input  logic                   i_Ltu,
  input  logic                   i_MemReady,
  output logic [1:0]             o_ALUOp,
  output logic                   o_Funct7Zero,
  output logic [1:0]             o_ALUSrcA,
  output logic [1:0]             o_ALUSrcB,
  output logic [1:0]             o_ResultSrc,
  output logic                   o_AdrSrc,
  output logic                   o_MemRead,
  output logic                   o_MemWrite,
  output logic                   o_IRWrite,
  output logic                   o_PCWrite,
  output logic                   o_RegWrite,
  output logic                   o_Retire,
  output logic                   o_Illegal,
  output logic [STALL_CNT_W-1:0] o_StallCnt
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr,
    StJalr2,
    StLui
`ifdef CONTROL_TRAP_EN
    , StTrap
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   opcode_legal;
  logic                   branch_taken;

  // Opcode is recognised by the decode dispatch.
  always_comb begin
    opcode_legal = i_Opcode inside {OpLoad, OpStore, OpAluR, OpAluI, OpBranch, OpJal, OpJalr,
                                    OpLui};
  end

  // Branch condition from ALU flags; funct3 010/011 have no branch meaning.
  always_comb begin
    branch_taken = 1'b0;
    case (i_Funct3)
      3'b000:  branch_taken = i_Zero;
      3'b001:  branch_taken = ~i_Zero;
      3'b100:  branch_taken = i_Lt;
      3'b101:  branch_taken = ~i_Lt;
      3'b110:  branch_taken = i_Ltu;
      3'b111:  branch_taken = ~i_Ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state dispatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (i_MemReady) state_d = StDecode;
      StDecode: begin
        case (i_Opcode)
          OpLoad, OpStore: state_d = StMemAddr;
          OpAluR:          state_d = StExecR;
          OpAluI:          state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
`ifdef CONTROL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      // Opcode bit 5 separates store (0100011) from load (0000011).
      StMemAddr:  state_d = i_Opcode[5] ? StMemWrite : StMemRead;
      StMemRead:  if (i_MemReady) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (i_MemReady) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StJalr:     state_d = StJalr2;
      StJalr2:    state_d = StFetch;
      StLui:      state_d = StAluWb;
`ifdef CONTROL_TRAP_EN
      StTrap:     state_d = StTrap;
`endif
      default:    state_d = StFetch;
    endcase
  end

  // Saturating count of cycles spent waiting on memory.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == StFetch || state_q == StMemRead || state_q == StMemWrite) && !i_MemReady &&
        stall_q != {STALL_CNT_W{1'b1}}) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // State and stall counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StFetch;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

`ifdef CONTROL_TRAP_EN
  logic illegal_q;

  // Sticky illegal flag, set on the transition into the trap state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == StDecode && !opcode_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign o_Illegal = illegal_q;
`else
  assign o_Illegal = 1'b0;
`endif

  assign o_StallCnt = stall_q;

  // Moore decode of selects/strobes; reset forces everything low immediately.
  always_comb begin
    o_ALUOp      = 2'b00;
    o_Funct7Zero = 1'b0;
    o_ALUSrcA    = 2'b00;
    o_ALUSrcB    = 2'b00;
    o_ResultSrc  = 2'b00;
    o_AdrSrc     = 1'b0;
    o_MemRead    = 1'b0;
    o_MemWrite   = 1'b0;
    o_IRWrite    = 1'b0;
    o_PCWrite    = 1'b0;
    o_RegWrite   = 1'b0;
    o_Retire     = 1'b0;
    case (state_q)
      StFetch: begin
        o_MemRead   = 1'b1;
        o_ALUSrcB   = 2'b01;
        o_ResultSrc = 2'b10;
        o_IRWrite   = i_MemReady;
        o_PCWrite   = i_MemReady;
      end
      StDecode: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b10;
`ifndef CONTROL_TRAP_EN
        // Unknown opcodes retire as a NOP.
        o_Retire  = ~opcode_legal;
`endif
      end
      StMemAddr: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b10;
      end
      StMemRead: begin
        o_AdrSrc  = 1'b1;
        o_MemRead = 1'b1;
      end
      StMemWb: begin
        o_ResultSrc = 2'b01;
        o_RegWrite  = 1'b1;
        o_Retire    = 1'b1;
      end
      StMemWrite: begin
        o_AdrSrc   = 1'b1;
        o_MemWrite = 1'b1;
        o_Retire   = i_MemReady;
      end
      StExecR: begin
        o_ALUSrcA = 2'b01;
        o_ALUOp   = 2'b10;
      end
      StExecI: begin
        o_ALUSrcA    = 2'b01;
        o_ALUSrcB    = 2'b10;
        o_ALUOp      = 2'b10;
        // Shift-right-immediate needs funct7 to tell SRLI from SRAI.
        o_Funct7Zero = (i_Funct3 != 3'b101);
      end
      StAluWb: begin
        o_RegWrite = 1'b1;
        o_Retire   = 1'b1;
      end
      StBranch: begin
        o_ALUSrcA = 2'b01;
        o_ALUOp   = 2'b01;
        o_Retire  = 1'b1;
        o_PCWrite = branch_taken;
      end
      StJal: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
        o_PCWrite = 1'b1;
      end
      StJalr: begin
        o_ALUSrcA   = 2'b01;
        o_ALUSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
        o_PCWrite   = 1'b1;
      end
      StJalr2: begin
        o_ALUSrcA   = 2'b10;
        o_ALUSrcB   = 2'b01;
        o_ResultSrc = 2'b10;
        o_RegWrite  = 1'b1;
        o_Retire    = 1'b1;
      end
      StLui: begin
        o_ALUSrcA = 2'b11;
        o_ALUSrcB = 2'b10;
      end
      default: ;
    endcase
    if (i_rst) begin
      o_ALUOp      = 2'b00;
      o_Funct7Zero = 1'b0;
      o_ALUSrcA    = 2'b00;
      o_ALUSrcB    = 2'b00;
      o_ResultSrc  = 2'b00;
      o_AdrSrc     = 1'b0;
      o_MemRead    = 1'b0;
      o_MemWrite   = 1'b0;
      o_IRWrite    = 1'b0;
      o_PCWrite    = 1'b0;
      o_RegWrite   = 1'b0;
      o_Retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: table vectors, hand-written
// multi-cycle sequences and randomized instructions against a phase-list model.
module tb_multicycle_main_control;

`ifdef CONTROL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [6:0]  i_Opcode;
  logic [2:0]  i_Funct3;
  logic        i_Zero, i_Lt, i_Ltu, i_MemReady;
  logic [1:0]  o_ALUOp, o_ALUSrcA, o_ALUSrcB, o_ResultSrc;
  logic        o_Funct7Zero, o_AdrSrc, o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite;
  logic        o_RegWrite, o_Retire, o_Illegal;
  logic [15:0] o_StallCnt;

  multicycle_main_control #(.STALL_CNT_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_Opcode     (i_Opcode),
    .i_Funct3     (i_Funct3),
    .i_Zero       (i_Zero),
    .i_Lt         (i_Lt),
    .i_Ltu        (i_Ltu),
    .i_MemReady   (i_MemReady),
    .o_ALUOp      (o_ALUOp),
    .o_Funct7Zero (o_Funct7Zero),
    .o_ALUSrcA    (o_ALUSrcA),
    .o_ALUSrcB    (o_ALUSrcB),
    .o_ResultSrc  (o_ResultSrc),
    .o_AdrSrc     (o_AdrSrc),
    .o_MemRead    (o_MemRead),
    .o_MemWrite   (o_MemWrite),
    .o_IRWrite    (o_IRWrite),
    .o_PCWrite    (o_PCWrite),
    .o_RegWrite   (o_RegWrite),
    .o_Retire     (o_Retire),
    .o_Illegal    (o_Illegal),
    .o_StallCnt   (o_StallCnt)
  );

  always #5 i_clk = ~i_clk;

  // {ALUOp, Funct7Zero, SrcA, SrcB, ResultSrc, AdrSrc, MemRead, MemWrite, IRWrite, PCWrite,
  //  RegWrite, Retire}
  logic [15:0] act;
  assign act = {o_ALUOp, o_Funct7Zero, o_ALUSrcA, o_ALUSrcB, o_ResultSrc, o_AdrSrc, o_MemRead,
                o_MemWrite, o_IRWrite, o_PCWrite, o_RegWrite, o_Retire};

  localparam logic [6:0] OpLoad = 7'b0000011, OpStore = 7'b0100011, OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011, OpBr = 7'b1100011, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpLui = 7'b0110111, OpBad = 7'b1111111;

  typedef struct {
    logic        ready;
    logic [15:0] exp;
    logic        stall;
    logic        set_ill;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    int         cyc;
  } cyc_vec_t;

  typedef struct {
    logic [2:0] f3;
    logic       z, lt, ltu, taken;
  } br_vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_stall = '0;
  logic        m_illegal = 1'b0;
  step_t       q[$];

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] pk(int aluop, int f7z, int sa, int sb, int rs, int adr, int mr,
                                     int mw, int ir, int pc, int rw, int ret);
    return {2'(aluop), 1'(f7z), 2'(sa), 2'(sb), 2'(rs), 1'(adr), 1'(mr), 1'(mw), 1'(ir), 1'(pc),
            1'(rw), 1'(ret)};
  endfunction

  function automatic step_t mk(logic rdy, logic [15:0] e, logic st, logic si);
    step_t s;
    s.ready = rdy; s.exp = e; s.stall = st; s.set_ill = si;
    return s;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle phase list of one instruction, derived from the ISA-level rules.
  task automatic build(logic [6:0] op, logic [2:0] f3, logic z, logic lt, logic ltu, int fw,
                       int mw);
    logic legal, taken;
    logic [15:0] aluwb;
    aluwb = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    q.delete();
    for (int i = 0; i < fw; i++) q.push_back(mk(1'b0, pk(0,0,0,1,2,0,1,0,0,0,0,0), 1'b1, 1'b0));
    q.push_back(mk(1'b1, pk(0,0,0,1,2,0,1,0,1,1,0,0), 1'b0, 1'b0));
    legal = op inside {OpLoad, OpStore, OpR, OpI, OpBr, OpJal, OpJalr, OpLui};
    q.push_back(mk(rnd1(), pk(0,0,2,2,0,0,0,0,0,0,0, int'(!legal && !TrapEn)), 1'b0,
                   !legal && TrapEn));
    if (!legal) begin
      if (TrapEn) for (int i = 0; i < 3; i++) q.push_back(mk(rnd1(), 16'h0, 1'b0, 1'b0));
      return;
    end
    case (op)
      OpLoad: begin
        q.push_back(mk(rnd1(), pk(0,0,1,2,0,0,0,0,0,0,0,0), 1'b0, 1'b0));
        for (int i = 0; i < mw; i++) q.push_back(mk(1'b0, pk(0,0,0,0,0,1,1,0,0,0,0,0), 1'b1, 1'b0));
        q.push_back(mk(1'b1, pk(0,0,0,0,0,1,1,0,0,0,0,0), 1'b0, 1'b0));
        q.push_back(mk(rnd1(), pk(0,0,0,0,1,0,0,0,0,0,1,1), 1'b0, 1'b0));
      end
      OpStore: begin
        q.push_back(mk(rnd1(), pk(0,0,1,2,0,0,0,0,0,0,0,0), 1'b0, 1'b0));
        for (int i = 0; i < mw; i++) q.push_back(mk(1'b0, pk(0,0,0,0,0,1,0,1,0,0,0,0), 1'b1, 1'b0));
        q.push_back(mk(1'b1, pk(0,0,0,0,0,1,0,1,0,0,0,1), 1'b0, 1'b0));
      end
      OpR: begin
        q.push_back(mk(rnd1(), pk(2,0,1,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0));
        q.push_back(mk(rnd1(), aluwb, 1'b0, 1'b0));
      end
      OpI: begin
        q.push_back(mk(rnd1(), pk(2, int'(f3 != 3'd5), 1,2,0,0,0,0,0,0,0,0), 1'b0, 1'b0));
        q.push_back(mk(rnd1(), aluwb, 1'b0, 1'b0));
      end
      OpBr: begin
        case (f3)
          3'd0: taken = z;    3'd1: taken = !z;
          3'd4: taken = lt;   3'd5: taken = !lt;
          3'd6: taken = ltu;  3'd7: taken = !ltu;
          default: taken = 1'b0;
        endcase
        q.push_back(mk(rnd1(), pk(1,0,1,0,0,0,0,0,0, int'(taken), 0,1), 1'b0, 1'b0));
      end
      OpJal: begin
        q.push_back(mk(rnd1(), pk(0,0,2,1,0,0,0,0,0,1,0,0), 1'b0, 1'b0));
        q.push_back(mk(rnd1(), aluwb, 1'b0, 1'b0));
      end
      OpJalr: begin
        q.push_back(mk(rnd1(), pk(0,0,1,2,2,0,0,0,0,1,0,0), 1'b0, 1'b0));
        q.push_back(mk(rnd1(), pk(0,0,2,1,2,0,0,0,0,0,1,1), 1'b0, 1'b0));
      end
      default: begin // lui
        q.push_back(mk(rnd1(), pk(0,0,3,2,0,0,0,0,0,0,0,0), 1'b0, 1'b0));
        q.push_back(mk(rnd1(), aluwb, 1'b0, 1'b0));
      end
    endcase
  endtask

  // One clock cycle: drive just after negedge, check, advance model at posedge.
  task automatic apply(step_t s, output logic ret, output logic pcw);
    i_MemReady = s.ready;
    #1;
    chk("ctl", 32'(act), 32'(s.exp));
    chk("stall_cnt", 32'(o_StallCnt), 32'(m_stall));
    chk("illegal", 32'(o_Illegal), 32'(m_illegal));
    ret = o_Retire;
    pcw = o_PCWrite;
    @(posedge i_clk);
    if (s.stall && m_stall != 16'hFFFF) m_stall++;
    if (s.set_ill) m_illegal = 1'b1;
    @(negedge i_clk);
  endtask

  // Runs one instruction; reports DUT cycles up to its first Retire and PCWrite on that cycle.
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic z, logic lt, logic ltu, int fw,
                           int mw, output int cycles, output logic pcw_ret);
    logic ret, pcw, got;
    i_Opcode = op; i_Funct3 = f3; i_Zero = z; i_Lt = lt; i_Ltu = ltu;
    build(op, f3, z, lt, ltu, fw, mw);
    cycles = 0; got = 1'b0; pcw_ret = 1'b0;
    foreach (q[i]) begin
      apply(q[i], ret, pcw);
      if (!got) cycles++;
      if (ret && !got) begin
        got = 1'b1;
        pcw_ret = pcw;
      end
    end
  endtask

  // Assert reset for a cycle, check forced-low outputs, release on a negedge.
  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_outputs", 32'(act), 32'h0);
    chk("rst_stall", 32'(o_StallCnt), 32'h0);
    chk("rst_illegal", 32'(o_Illegal), 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    m_stall = '0;
    m_illegal = 1'b0;
  endtask

  cyc_vec_t cyc_tab[8];
  br_vec_t  br_tab[8];
  logic     ret, pcw;
  int       cycles;
  logic [6:0] ops[9];

  initial begin
    i_rst = 1'b1; i_Opcode = '0; i_Funct3 = '0; i_Zero = 0; i_Lt = 0; i_Ltu = 0;
    i_MemReady = 1'b0;

    cyc_tab[0] = '{OpR, 3'd0, 4};    cyc_tab[1] = '{OpI, 3'd0, 4};
    cyc_tab[2] = '{OpLui, 3'd0, 4};  cyc_tab[3] = '{OpJal, 3'd0, 4};
    cyc_tab[4] = '{OpJalr, 3'd0, 4}; cyc_tab[5] = '{OpBr, 3'd0, 3};
    cyc_tab[6] = '{OpLoad, 3'd2, 5}; cyc_tab[7] = '{OpStore, 3'd2, 4};

    br_tab[0] = '{3'b000, 1, 0, 0, 1}; br_tab[1] = '{3'b001, 1, 0, 0, 0};
    br_tab[2] = '{3'b110, 0, 0, 1, 1}; br_tab[3] = '{3'b010, 1, 1, 1, 0};
    br_tab[4] = '{3'b101, 0, 0, 0, 1}; br_tab[5] = '{3'b100, 0, 1, 0, 1};
    br_tab[6] = '{3'b111, 0, 0, 1, 0}; br_tab[7] = '{3'b000, 0, 1, 1, 0};

    @(negedge i_clk);
    do_reset();

    // Zero-wait instruction latencies.
    foreach (cyc_tab[i]) begin
      run_instr(cyc_tab[i].op, cyc_tab[i].f3, 1'b0, 1'b0, 1'b0, 0, 0, cycles, pcw);
      chk($sformatf("latency_op%07b", cyc_tab[i].op), 32'(cycles), 32'(cyc_tab[i].cyc));
    end

    // Branch condition table.
    foreach (br_tab[i]) begin
      run_instr(OpBr, br_tab[i].f3, br_tab[i].z, br_tab[i].lt, br_tab[i].ltu, 0, 0, cycles, pcw);
      chk($sformatf("branch_taken_f3_%03b", br_tab[i].f3), 32'(pcw), 32'(br_tab[i].taken));
    end

    // EXECI funct7 forcing, shift-right vs add.
    run_instr(OpI, 3'b101, 0, 0, 0, 0, 0, cycles, pcw);
    run_instr(OpI, 3'b000, 0, 0, 0, 0, 0, cycles, pcw);

    // Load with three memory wait cycles.
    do_reset();
    run_instr(OpLoad, 3'd2, 0, 0, 0, 0, 3, cycles, pcw);
    chk("load_wait_stall_cnt", 32'(o_StallCnt), 32'd3);
    chk("load_wait_latency", 32'(cycles), 32'd8);

    // Illegal opcode.
    do_reset();
    run_instr(OpBad, 3'd0, 0, 0, 0, 0, 0, cycles, pcw);
`ifdef CONTROL_TRAP_EN
    chk("trap_illegal_flag", 32'(o_Illegal), 32'd1);
    chk("trap_no_memread", 32'(o_MemRead), 32'd0);
`else
    chk("illegal_nop_latency", 32'(cycles), 32'd2);
    i_MemReady = 1'b0;
    #1;
    chk("illegal_then_fetch", 32'(o_MemRead), 32'd1);
    @(negedge i_clk);
    m_stall++;
`endif

    // Reset asserted while a store is waiting on memory.
    do_reset();
    i_Opcode = OpStore; i_Funct3 = 3'd2;
    apply(mk(1'b1, pk(0,0,0,1,2,0,1,0,1,1,0,0), 1'b0, 1'b0), ret, pcw);
    apply(mk(1'b0, pk(0,0,2,2,0,0,0,0,0,0,0,0), 1'b0, 1'b0), ret, pcw);
    apply(mk(1'b0, pk(0,0,1,2,0,0,0,0,0,0,0,0), 1'b0, 1'b0), ret, pcw);
    apply(mk(1'b0, pk(0,0,0,0,0,1,0,1,0,0,0,0), 1'b1, 1'b0), ret, pcw);
    i_MemReady = 1'b0;
    #1;
    chk("store_wait_memwrite", 32'(o_MemWrite), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_mid_memwrite", 32'(o_MemWrite), 32'd0);
    chk("rst_mid_outputs", 32'(act), 32'h0);
    chk("rst_mid_stall", 32'(o_StallCnt), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    m_stall = '0;
    apply(mk(1'b0, pk(0,0,0,1,2,0,1,0,0,0,0,0), 1'b1, 1'b0), ret, pcw);

    // Randomized instruction stream.
    do_reset();
    ops = '{OpLoad, OpStore, OpR, OpI, OpBr, OpJal, OpJalr, OpLui, 7'b0001111};
    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, TrapEn ? 7 : 8);
      run_instr(ops[k], 3'($urandom), rnd1(), rnd1(), rnd1(), $urandom_range(0, 3),
                $urandom_range(0, 3), cycles, pcw);
    end

    // Stall counter saturation.
    do_reset();
    i_MemReady = 1'b0;
    repeat (65535) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("stall_reaches_max", 32'(o_StallCnt), 32'hFFFF);
    repeat (70000 - 65535) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("stall_saturated", 32'(o_StallCnt), 32'hFFFF);
    chk("stall_fetch_memread", 32'(o_MemRead), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control FSM for the SOIN-RV multi-cycle RV32I core; the upstream producer of the ALUOp code that ALU_CONTROL consumes. It sequences fetch/decode/execute/memory/writeback, drives all datapath mux selects and write enables, and handshakes with a variable-latency memory. ALU operation selection below the ALUOp level (funct decoding) stays in ALU_CONTROL.

## Interface
- STALL_CNT_W, 16, width of the saturating memory-stall counter
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_Opcode  in  7  IR[6:0]
- i_Funct3  in  3  IR[14:12]
- i_Zero, i_Lt, i_Ltu  in  1 each  ALU flags: result zero, signed less-than, unsigned less-than
- i_MemReady  in  1  memory completes the current read/write this cycle
- o_ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- o_Funct7Zero  out  1  datapath forces Funct7 to 0 toward ALU_CONTROL
- o_ALUSrcA  out  2  00 PC, 01 reg A, 10 OldPC, 11 zero
- o_ALUSrcB  out  2  00 reg B, 01 const 4, 10 immediate
- o_ResultSrc  out  2  00 ALUOut, 01 memory data reg, 10 ALU result
- o_AdrSrc  out  1  memory address: 0 PC, 1 ALUOut
- o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite, o_RegWrite  out  1 each  strobes
- o_Retire  out  1  pulse on last cycle of each instruction
- o_Illegal  out  1  sticky illegal-opcode flag
- o_StallCnt  out  STALL_CNT_W  memory-wait cycle count

## Operation
- States: FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR2, LUI, TRAP. Unlisted outputs are 0.
- FETCH: AdrSrc=0, MemRead=1, SrcA=00, SrcB=01, ALUOp=00, ResultSrc=10. If i_MemReady: IRWrite=1, PCWrite=1, ->DECODE; else hold.
- DECODE: SrcA=10, SrcB=10, ALUOp=00 (branch/JAL target into ALUOut). Opcode dispatch: 0000011/0100011->MEMADDR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, else illegal.
- MEMADDR: SrcA=01, SrcB=10, ALUOp=00; ->MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AdrSrc=1, MemRead=1; on ready ->MEMWB. MEMWB: ResultSrc=01, RegWrite=1, Retire=1 ->FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1; on ready Retire=1 ->FETCH.
- EXECR: SrcA=01, SrcB=00, ALUOp=10 ->ALUWB. EXECI: as EXECR with SrcB=10, Funct7Zero=1 unless Funct3=101 ->ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 ->FETCH.
- BRANCH: SrcA=01, SrcB=00, ALUOp=01, ResultSrc=00, Retire=1; PCWrite=taken: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu; Funct3 010/011 never taken. ->FETCH.
- JAL: SrcA=10, SrcB=01, ALUOp=00, ResultSrc=00, PCWrite=1 ->ALUWB (writes OldPC+4).
- JALR: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1 (datapath clears bit 0) ->JALR2: SrcA=10, SrcB=01, ResultSrc=10, RegWrite=1, Retire=1 ->FETCH.
- LUI: SrcA=11, SrcB=10, ALUOp=00 ->ALUWB.
- o_StallCnt: +1 each cycle in FETCH/MEMREAD/MEMWRITE with i_MemReady=0; saturates at all-ones, never wraps.

## Timing
- Moore outputs from state register, except FETCH IRWrite/PCWrite (gated by i_MemReady) and BRANCH PCWrite (gated by flags).
- Reset: state=FETCH, o_StallCnt=0, o_Illegal=0; while i_rst=1 all strobes and selects forced to 0. First MemRead in the cycle after deassertion.
- Reset mid-operation: immediate return to FETCH; any outstanding memory request abandoned, no write enable asserted.
- Cycles with zero-wait memory: R/I/LUI/JAL 4, JALR 4, branch 3, load 5, store 4. Each memory wait cycle adds one.
- i_MemReady outside memory states ignored.

## Configuration
- CONTROL_TRAP_EN defined: illegal opcode in DECODE ->TRAP; TRAP sets o_Illegal=1, all strobes 0, no Retire, stays until reset.
- Undefined: illegal opcode treated as NOP: DECODE asserts Retire=1 ->FETCH; o_Illegal tied 0; TRAP state absent.

## Test plan
- Reset, i_MemReady=1, Opcode=0110011: FETCH->DECODE->EXECR->ALUWB; ALUOp=10 in EXECR, RegWrite and Retire in cycle 4.
- Opcode=0010011, Funct3=101 vs 000: Funct7Zero=0 vs 1 in EXECI, ALUOp=10.
- Load with i_MemReady low 3 cycles in MEMREAD: MemRead held 4 cycles, AdrSrc=1, o_StallCnt=3, RegWrite with ResultSrc=01 in MEMWB.
- Branch Funct3=000 with i_Zero=1 -> PCWrite=1; Funct3=001 i_Zero=1 -> PCWrite=0; Funct3=110 i_Ltu=1 -> PCWrite=1; ALUOp=01 all cases.
- Opcode=1111111: with CONTROL_TRAP_EN o_Illegal=1, no further MemRead until reset; without, Retire in DECODE, next cycle FETCH.
- i_rst pulsed during MEMWRITE with MemReady low: MemWrite drops immediately, o_StallCnt=0, FETCH after release; o_StallCnt=2^16-1 held after 70000 stall cycles.
